// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   OP_*   : opcodes the unit responds to
//   F3_*   : funct3 access-size / sign codes
//   state_t: FSM state encoding, also exported on the debug port
//   access_ok(): legality check of an access (size code + alignment)
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT_R = 3'd2,
        S_RESP   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    // Unsupported size codes are folded into "not ok" so they take the same
    // error path as a misaligned address.
    function automatic logic access_ok(input logic [6:0] opcode,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~offset[0];
            F3_W:    ok = (offset == 2'b00);
            F3_BU:   ok = (opcode == OP_LOAD);
            F3_HU:   ok = (opcode == OP_LOAD) && ~offset[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : request, driven by master
//   mem_gnt    : request taken; meaningful only while mem_req is high
//   mem_rvalid : read data valid on mem_rdata
// Handshake: a request stays asserted with stable fields until the cycle
// mem_gnt is seen high on a rising edge; read data is then returned by a
// later single-cycle mem_rvalid pulse.
interface load_store_unit_if #(parameter int WIDTH = 32);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_extend.sv
// Load lane selection and extension (combinational).
//   rdata  : full word returned by memory
//   offset : byte offset of the access within the word
//   funct3 : size/sign code of the load
//   data   : right-aligned, sign- or zero-extended result
module load_extend
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       offset,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Halves are always aligned here, so only offset[1] picks the half.
    assign lane_b = rdata[{offset, 3'b000} +: 8];
    assign lane_h = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{(WIDTH-8){lane_b[7]}}, lane_b};
            F3_BU:   data = {{(WIDTH-8){1'b0}}, lane_b};
            F3_H:    data = {{(WIDTH-16){lane_h[15]}}, lane_h};
            F3_HU:   data = {{(WIDTH-16){1'b0}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one load or store from the execute stage, runs it
// on the data-memory bus and returns extended load data.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   opcode, funct3, addr, wdata : request fields, captured on accept
//   mem                 : data-memory bus (master side)
//   ld_data             : last completed load result
//   done / misalign     : one-cycle completion / error pulses
//   busy                : high whenever not IDLE
//   dbg_state           : current FSM state
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [WIDTH-1:0]     addr,
    input  logic [WIDTH-1:0]     wdata,
    load_store_unit_if.master    mem,
    output logic [WIDTH-1:0]     ld_data,
    output logic                 done,
    output logic                 misalign,
    output logic                 busy,
    output state_t               dbg_state
);

    state_t           state, state_next;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] ld_data_q;
    logic [WIDTH-1:0] ld_ext;
    logic [WIDTH-1:0] wdata_lanes;
    logic [3:0]       strb;
    logic             is_mem_op;
    logic             accept;
    logic             is_store_q;

    assign is_mem_op  = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign req_ready  = (state == S_IDLE);
    assign accept     = req_valid && req_ready && is_mem_op;
    assign is_store_q = (opcode_q == OP_STORE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_next = access_ok(opcode, funct3, addr[1:0]) ? S_REQ : S_ERR;
            end
            S_REQ: begin
                if (mem.mem_gnt)
                    state_next = is_store_q ? S_RESP : S_WAIT_R;
            end
            S_WAIT_R: begin
                if (mem.mem_rvalid) state_next = S_RESP;
            end
            S_RESP:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request fields are frozen at accept so the upstream stage may change
    // its outputs while the transaction is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= '0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            opcode_q <= opcode;
            funct3_q <= funct3;
            addr_q   <= addr;
            wdata_q  <= wdata;
        end
    end

    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .rdata  (mem.mem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (ld_ext)
    );

    // Read data is only taken in WAIT_R, so a return that belongs to a
    // transaction aborted by reset is dropped.
    always_ff @(posedge clk) begin
        if (rst)                                   ld_data_q <= '0;
        else if (state == S_WAIT_R && mem.mem_rvalid) ld_data_q <= ld_ext;
    end

    always_comb begin
        wdata_lanes = wdata_q;
        case (funct3_q)
            F3_B:    wdata_lanes = {(WIDTH/8){wdata_q[7:0]}};
            F3_H:    wdata_lanes = {(WIDTH/16){wdata_q[15:0]}};
            default: wdata_lanes = wdata_q;
        endcase
    end

    always_comb begin
        strb = 4'b0000;
        if (is_store_q) begin
            case (funct3_q)
                F3_B:    strb = 4'b0001 << addr_q[1:0];
                F3_H:    strb = 4'b0011 << addr_q[1:0];
                F3_W:    strb = 4'b1111;
                default: strb = 4'b0000;
            endcase
        end
    end

    assign mem.mem_req   = (state == S_REQ);
    assign mem.mem_we    = (state == S_REQ) && is_store_q;
    assign mem.mem_wstrb = (state == S_REQ) ? strb : 4'b0000;
    assign mem.mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
    assign mem.mem_wdata = wdata_lanes;

    assign ld_data   = ld_data_q;
    assign done      = (state == S_RESP);
    assign misalign  = (state == S_ERR);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] ld_data;
  logic        done;
  logic        misalign;
  logic        busy;
  state_t      dbg_state;

  load_store_unit_if #(.WIDTH(32)) mem_if ();

  load_store_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .mem       (mem_if),
    .ld_data   (ld_data),
    .done      (done),
    .misalign  (misalign),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_ld = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return d;
    endcase
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic        exp_err;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdat, input int gd,
                              input int rd, input logic err, input logic [3:0] ws,
                              input logic [31:0] mwd, input logic [31:0] ld);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat;
    v.gd = gd; v.rd = rd; v.exp_err = err; v.exp_wstrb = ws;
    v.exp_wdata = mwd; v.exp_ld = ld;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input string tag, input vec_t v);
    logic is_store;
    logic [31:0] exp_maddr;
    logic [31:0] got;
    is_store  = (v.op == OP_STORE);
    exp_maddr = {v.addr[31:2], 2'b00};
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; opcode = v.op; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    if (!v.exp_err && !is_store) model_ld = v.exp_ld;
    exp_q.push_back(model_ld);
    step();
    req_valid = 1'b0; opcode = 7'h0; funct3 = 3'h0; addr = $urandom; wdata = $urandom;
    if (v.exp_err) begin
      chk({tag, " misalign"}, 32'(misalign), 32'd1);
      chk({tag, " no_req"}, 32'(mem_if.mem_req), 32'd0);
      step();
      chk({tag, " misalign_end"}, 32'(misalign), 32'd0);
      chk({tag, " idle"}, 32'(busy), 32'd0);
      chk({tag, " no_req2"}, 32'(mem_if.mem_req), 32'd0);
      got = exp_q.pop_front();
      chk({tag, " ld_hold"}, ld_data, got);
      return;
    end
    chk({tag, " state_req"}, 32'(dbg_state), 32'(S_REQ));
    chk({tag, " mem_req"}, 32'(mem_if.mem_req), 32'd1);
    chk({tag, " mem_addr"}, mem_if.mem_addr, exp_maddr);
    chk({tag, " mem_we"}, 32'(mem_if.mem_we), 32'(is_store));
    chk({tag, " mem_wstrb"}, 32'(mem_if.mem_wstrb), 32'(v.exp_wstrb));
    if (is_store) chk({tag, " mem_wdata"}, mem_if.mem_wdata, v.exp_wdata);
    for (int k = 0; k < v.gd; k++) begin
      // competing request and stray read return while waiting for grant
      req_valid = 1'b1; opcode = OP_LOAD; funct3 = F3_W; addr = v.addr ^ 32'h40;
      mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hFFFF_FFFF;
      step();
      chk({tag, " stall_ready"}, 32'(req_ready), 32'd0);
      chk({tag, " stall_req"}, 32'(mem_if.mem_req), 32'd1);
      chk({tag, " stall_addr"}, mem_if.mem_addr, exp_maddr);
      chk({tag, " stall_wstrb"}, 32'(mem_if.mem_wstrb), 32'(v.exp_wstrb));
    end
    req_valid = 1'b0; opcode = 7'h0; mem_if.mem_rvalid = 1'b0;
    mem_if.mem_gnt = 1'b1;
    step();
    mem_if.mem_gnt = 1'b0;
    if (!is_store) begin
      for (int k = 0; k < v.rd; k++) begin
        chk({tag, " wait_r"}, 32'(dbg_state), 32'(S_WAIT_R));
        step();
      end
      chk({tag, " no_done_early"}, 32'(done), 32'd0);
      mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = v.rdata;
      step();
      mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = $urandom;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    got = exp_q.pop_front();
    chk({tag, " ld_data"}, ld_data, got);
    step();
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " back_idle"}, 32'(busy), 32'd0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[$];

  initial begin
    rst = 1'b1; req_valid = 1'b0; opcode = '0; funct3 = '0; addr = '0; wdata = '0;
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;

    vecs.push_back(mk(OP_LOAD,  F3_W,  32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 4'b0000, 0, 32'hDEADBEEF));
    vecs.push_back(mk(OP_LOAD,  F3_B,  32'h103, 0, 32'h80FF0011, 0, 0, 0, 4'b0000, 0, 32'hFFFFFF80));
    vecs.push_back(mk(OP_LOAD,  F3_BU, 32'h103, 0, 32'h80FF0011, 0, 1, 0, 4'b0000, 0, 32'h00000080));
    vecs.push_back(mk(OP_STORE, F3_H,  32'h202, 32'h1234ABCD, 0, 0, 0, 0, 4'b1100, 32'hABCDABCD, 0));
    vecs.push_back(mk(OP_LOAD,  F3_W,  32'h101, 0, 0, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(OP_STORE, F3_B,  32'h001, 32'h000000A5, 0, 0, 0, 0, 4'b0010, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(OP_STORE, F3_W,  32'h30C, 32'hCAFEF00D, 0, 1, 0, 0, 4'b1111, 32'hCAFEF00D, 0));
    vecs.push_back(mk(OP_LOAD,  F3_H,  32'h402, 0, 32'h80017FFF, 0, 0, 0, 4'b0000, 0, 32'hFFFF8001));
    vecs.push_back(mk(OP_LOAD,  F3_HU, 32'h402, 0, 32'h80017FFF, 1, 0, 0, 4'b0000, 0, 32'h00008001));
    vecs.push_back(mk(OP_LOAD,  F3_H,  32'h400, 0, 32'h80017FFF, 0, 0, 0, 4'b0000, 0, 32'h00007FFF));
    vecs.push_back(mk(OP_LOAD,  F3_B,  32'h101, 0, 32'h12345678, 0, 0, 0, 4'b0000, 0, 32'h00000056));
    vecs.push_back(mk(OP_LOAD,  F3_H,  32'h403, 0, 0, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(OP_STORE, F3_W,  32'h502, 32'h1, 0, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(OP_STORE, 3'd3,  32'h600, 32'h1, 0, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(OP_STORE, F3_BU, 32'h600, 32'h1, 0, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(OP_LOAD,  3'd3,  32'h600, 0, 0, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(OP_LOAD,  3'd6,  32'h600, 0, 0, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(OP_LOAD,  F3_W,  32'h700, 0, 32'h0BADF00D, 3, 2, 0, 4'b0000, 0, 32'h0BADF00D));
    vecs.push_back(mk(OP_STORE, F3_B,  32'h7FF, 32'h11, 0, 2, 0, 0, 4'b1000, 32'h11111111, 0));

    // reset values
    step(); step();
    chk("rst_busy_held", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    chk("rst_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 32'd0);

    // non-memory opcode is ignored
    req_valid = 1'b1; opcode = 7'b0110011; funct3 = F3_W; addr = 32'h800;
    step();
    req_valid = 1'b0;
    chk("ignore_busy", 32'(busy), 32'd0);
    chk("ignore_ready", 32'(req_ready), 32'd1);
    chk("ignore_mem_req", 32'(mem_if.mem_req), 32'd0);

    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);

    // random aligned loads with random bus timing
    for (int r = 0; r < 12; r++) begin
      vec_t v;
      logic [2:0] f3;
      logic [1:0] off;
      logic [31:0] rdat;
      case ($urandom_range(0, 4))
        0:       f3 = F3_B;
        1:       f3 = F3_BU;
        2:       f3 = F3_H;
        3:       f3 = F3_HU;
        default: f3 = F3_W;
      endcase
      off = 2'($urandom_range(0, 3));
      if (f3 == F3_H || f3 == F3_HU) off[0] = 1'b0;
      if (f3 == F3_W) off = 2'b00;
      rdat = $urandom;
      v = mk(OP_LOAD, f3, {20'h0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), off},
             0, rdat, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, 4'b0000, 0,
             ext_model(f3, off, rdat));
      run_txn($sformatf("rnd%0d", r), v);
    end

    // reset during WAIT_R, then a late read return
    req_valid = 1'b1; opcode = OP_LOAD; funct3 = F3_W; addr = 32'h104;
    step();
    req_valid = 1'b0;
    mem_if.mem_gnt = 1'b1;
    step();
    mem_if.mem_gnt = 1'b0;
    chk("abort_in_wait_r", 32'(dbg_state), 32'(S_WAIT_R));
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_ld = 32'h0;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h5555AAAA;
    step();
    mem_if.mem_rvalid = 1'b0;
    chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ld_data", ld_data, model_ld);
    chk("abort_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("abort_mem_addr", mem_if.mem_addr, 32'd0);
    chk("abort_mem_wdata", mem_if.mem_wdata, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_misalign", 32'(misalign), 32'd0);
    step();
    chk("abort_done_later", 32'(done), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
